// File: rtl/fifo_stream_reader_if.sv
// FIFO drain port plus valid/ready stream port of fifo_stream_reader.
// master = the reader side, slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_wr_busy;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_wr_busy, fifo_rdata, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_wr_busy, fifo_rdata, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 2-entry output buffer. Optional packet framing: STREAM_LAST_EN.
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    fifo_stream_reader_if.master bus,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    if (PKT_LEN < 1) begin : g_pkt_len_check
        $error("fifo_stream_reader: PKT_LEN must be >= 1");
    end

    state_e             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;

    logic               hs;
    logic               fetch_ok;
    logic               rd_en;
    logic               drained;
    logic [1:0]         pending;
    logic [1:0]         occ_after_hs;

`ifdef STREAM_LAST_EN
    localparam int             PW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0]  PKT_MAX = PW'(PKT_LEN - 1);

    // pkt_q tracks delivered words, fet_q tracks fetched words, both modulo PKT_LEN.
    logic [PW-1:0]      pkt_q, pkt_d;
    logic [PW-1:0]      fet_q, fet_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its held value so no latch is inferred.
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        hs         = m_valid_q & bus.m_ready;
        pending    = occ_q + {1'b0, inflight_q};

`ifdef STREAM_LAST_EN
        // A drain still finishes fetching the packet it has started.
        fetch_ok   = (state_q == RUN) || ((state_q == DRAIN) && (fet_q != '0));
        drained    = !inflight_q && (occ_q == 2'd0) && (fet_q == '0);
`else
        fetch_ok   = (state_q == RUN);
        drained    = !inflight_q && (occ_q == 2'd0);
`endif

        rd_en      = fetch_ok && !bus.fifo_empty && !bus.fifo_wr_busy &&
                     ((pending < 2'd2) || ((pending == 2'd2) && hs));
        inflight_d = rd_en;

        // Pop the head first, then land any returning word in the first free slot.
        occ_after_hs = occ_q - {1'b0, hs};
        if (hs) begin
            head_d = tail_q;
        end
        if (inflight_q) begin
            if (occ_after_hs == 2'd0) begin
                head_d = bus.fifo_rdata;
            end else begin
                tail_d = bus.fifo_rdata;
            end
        end
        occ_d     = occ_after_hs + {1'b0, inflight_q};
        m_valid_d = (occ_d != 2'd0);
        xfer_d    = xfer_q + CNT_W'(hs);

        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);

`ifdef STREAM_LAST_EN
        pkt_d = pkt_q;
        fet_d = fet_q;
        if (hs) begin
            pkt_d = (pkt_q == PKT_MAX) ? '0 : pkt_q + 1'b1;
        end
        if (rd_en) begin
            fet_d = (fet_q == PKT_MAX) ? '0 : fet_q + 1'b1;
        end
        m_last_d = m_valid_d && (pkt_d == PKT_MAX);
`else
        m_last_d = 1'b0;
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            // NOTE: the buffer is reset too, because m_data must read 0 out of reset.
            head_q     <= '0;
            tail_q     <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            xfer_q     <= '0;
`ifdef STREAM_LAST_EN
            pkt_q      <= '0;
            fet_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            xfer_q     <= xfer_d;
`ifdef STREAM_LAST_EN
            pkt_q      <= pkt_d;
            fet_q      <= fet_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = head_q;
    assign bus.m_last     = m_last_q;
    assign busy           = busy_q;
    assign xfer_count     = xfer_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural synchronous FIFO
// with 1-cycle read latency and write-priority collisions.
module tb_fifo_stream_reader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
`ifdef STREAM_LAST_EN
    localparam int DRAIN_WORDS = 4;
`else
    localparam int DRAIN_WORDS = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             m_ready;
    logic             wr_busy;
    logic             busy;
    logic [CNT_W-1:0] xfer_count;

    logic [WIDTH-1:0] mem [64];
    logic [5:0]       wr_ptr;
    logic [5:0]       rd_ptr;
    logic [WIDTH-1:0] rdata = '0;
    int               pop_cnt   = 0;
    int               busy_pops = 0;
    logic             underflow = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int delivered;
    int p0;

    fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_wr_busy = wr_busy;
    assign bus.fifo_rdata   = rdata;
    assign bus.m_ready      = m_ready;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PKT_LEN(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // FIFO read side: write has priority, empty pops raise underflow.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
        end else if (bus.fifo_rd_en) begin
            if (wr_busy) begin
                busy_pops <= busy_pops + 1;
            end else if (wr_ptr == rd_ptr) begin
                underflow <= 1'b1;
            end else begin
                rdata   <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 6'd1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_ptr  = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        wr_busy = 1'b0;
        wr_ptr  = '0;
        repeat (2) @(negedge clk);

        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_rd_en",   32'(bus.fifo_rd_en), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_xfer",    32'(xfer_count), 32'd0);
        check("rst_m_data",  32'(bus.m_data), 32'd0);
        check("rst_m_last",  32'(bus.m_last), 32'd0);
        reset_n = 1'b1;

        // Basic ordering and first-word latency.
        push(8'h11); push(8'h22); push(8'h33);
        tick();
        check("idle_no_pop", 32'(bus.fifo_rd_en), 32'd0);
        check("idle_busy",   32'(busy), 32'd0);
        m_ready = 1'b1;
        enable  = 1'b1;
        tick();
        check("run_busy",  32'(busy), 32'd1);
        check("run_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        check("lat_e2_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("basic_w0", {23'd0, bus.m_valid, bus.m_data}, 32'h111);
        tick();
        check("basic_w1", {23'd0, bus.m_valid, bus.m_data}, 32'h122);
        check("empty_no_pop", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        check("basic_w2", {23'd0, bus.m_valid, bus.m_data}, 32'h133);
        tick();
        check("basic_done_valid", 32'(bus.m_valid), 32'd0);
        check("basic_xfer",       32'(xfer_count), 32'd3);

        // Backpressure: two words buffered, head held, then 1 word/cycle.
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        repeat (10) tick();
        check("bp_pops", 32'(pop_cnt - p0), 32'd2);
        check("bp_hold", {23'd0, bus.m_valid, bus.m_data}, 32'h1A0);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("bp_word", {23'd0, bus.m_valid, bus.m_data}, 32'h1A0 + 32'(i));
            tick();
        end
        check("bp_done_valid", 32'(bus.m_valid), 32'd0);
        check("bp_xfer",       32'(xfer_count), 32'd19);

        // Write collisions on alternate cycles, each busy cycle appends a word.
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        delivered = 0;
        for (int k = 0; k < 40; k++) begin
            wr_busy = (k < 12) && (k % 2 == 1);
            if (wr_busy) push(8'hC8 + 8'(k / 2));
            if (bus.m_valid) begin
                check("col_word", 32'(bus.m_data), 32'hC0 + 32'(delivered));
                delivered++;
            end
            tick();
        end
        wr_busy = 1'b0;
        check("col_count",     32'(delivered), 32'd14);
        check("col_busy_pops", 32'(busy_pops), 32'd0);
        check("col_xfer",      32'(xfer_count), 32'd33);

        // Drain from a full buffer with a pop in the enable-fall cycle.
        m_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
        p0 = pop_cnt;
        repeat (6) tick();
        check("drn_hold", {23'd0, bus.m_valid, bus.m_data}, 32'h1D0);
        enable   = 1'b0;
        m_ready  = 1'b1;
        delivered = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.m_valid) begin
                check("drn_word", 32'(bus.m_data), 32'hD0 + 32'(delivered));
                delivered++;
            end
            tick();
        end
        check("drn_count", 32'(delivered), 32'(DRAIN_WORDS));
        check("drn_pops",  32'(pop_cnt - p0), 32'(DRAIN_WORDS));
        check("drn_idle",  32'(busy), 32'd0);
        check("drn_xfer",  32'(xfer_count), 32'(DRAIN_WORDS));

        // Asynchronous reset between edges, then a clean restart.
        enable = 1'b1;
        repeat (4) tick();
        check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        wr_ptr  = '0;
        #1;
        check("arst_m_valid", 32'(bus.m_valid), 32'd0);
        check("arst_rd_en",   32'(bus.fifo_rd_en), 32'd0);
        check("arst_busy",    32'(busy), 32'd0);
        check("arst_xfer",    32'(xfer_count), 32'd0);
        push(8'hE0); push(8'hE1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rs_e1_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("rs_e2_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("rs_w0", {23'd0, bus.m_valid, bus.m_data}, 32'h1E0);
        tick();
        check("rs_w1", {23'd0, bus.m_valid, bus.m_data}, 32'h1E1);
        tick();
        check("rs_done_valid", 32'(bus.m_valid), 32'd0);
        check("rs_xfer",       32'(xfer_count), 32'd2);

`ifdef STREAM_LAST_EN
        // Drain completes the open packet: words 0..7 of 10.
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        p0 = pop_cnt;
        delivered = 0;
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 7) enable = 1'b0;
            if (bus.m_valid) begin
                check("pkt_word", {23'd0, bus.m_last, bus.m_data},
                      ((delivered % 4 == 3) ? 32'h100 : 32'h000) + 32'h30 + 32'(delivered));
                delivered++;
            end
            tick();
        end
        check("pkt_count", 32'(delivered), 32'd8);
        check("pkt_pops",  32'(pop_cnt - p0), 32'd8);
        check("pkt_idle",  32'(busy), 32'd0);
`endif

        check("underflow", 32'(underflow), 32'd0);
        check("busy_pops", 32'(busy_pops), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
